// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//
// Scan timing generator for a 640x480 @ 60 Hz VGA display. A divider derives
// the pixel-rate enable (p_tick) from the system clock. Horizontal and
// vertical scan counters advance once per p_tick. The generator produces
// active-low sync pulses and the visible-area flag for the pixel generator.
//
// Ports:
//   clk        in   system clock (100 MHz nominal)
//   reset      in   asynchronous reset, active low (0 = in reset)
//   hsync      out  horizontal sync, active low, registered
//   vsync      out  vertical sync, active low, registered
//   video_on   out  high while (x, y) lies inside the visible area
//   p_tick     out  one-clk pixel enable, once every CLK_DIV clocks
//   x          out  horizontal count, 0..H_TOTAL-1
//   y          out  vertical count, 0..V_TOTAL-1
//   frame_tick out  (only with VGA_FRAME_TICK_EN) one-clk pulse on the edge
//                   where the scan wraps from the last pixel back to (0,0)
//
// Build option:
//   VGA_FRAME_TICK_EN - when defined, adds the frame_tick output.
//
// The counters are 10 bits wide, so H_TOTAL and V_TOTAL must not exceed
// 1024. The valid range for CLK_DIV is 1..16.
//
// The pixel generator detects its per-frame refresh point as (y==481, x==0).
// That point is held for a whole pixel period. When CLK_DIV > 1, any logic
// keyed on it must also qualify with p_tick.
// ---------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y
`ifdef VGA_FRAME_TICK_EN
  ,
  output logic       frame_tick
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VISIBLE  = 10'(H_DISPLAY);
  localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_FINAL   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);

  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VISIBLE  = 10'(V_DISPLAY);
  localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_FINAL   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Inclusive window test used for both sync pulses.
  function automatic logic in_window(input logic [9:0] cnt,
                                     input logic [9:0] first,
                                     input logic [9:0] last);
    return (cnt >= first) && (cnt <= last);
  endfunction

  logic [3:0] div_cnt;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_nxt_p0;
  logic [9:0] v_nxt_p0;
  logic       h_last_p0;
  logic       v_last_p0;
  logic       hsync_p1;
  logic       vsync_p1;

  // ---- stage p0: divider, end-of-line/frame detect, next counter values ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

  // With CLK_DIV == 1, DIV_LAST is 0, so div_cnt stays at 0 and p_tick is
  // held at 1.
  assign p_tick    = (div_cnt == DIV_LAST);
  assign h_last_p0 = (h_cnt == H_LAST);
  assign v_last_p0 = (v_cnt == V_LAST);

  always_comb begin
    h_nxt_p0 = h_cnt;
    v_nxt_p0 = v_cnt;
    if (p_tick) begin
      if (h_last_p0) begin
        h_nxt_p0 = '0;
        v_nxt_p0 = v_last_p0 ? '0 : (v_cnt + 10'd1);
      end else begin
        h_nxt_p0 = h_cnt + 10'd1;
      end
    end
  end

  // ---- stage p1: registered counters and syncs ----
  // The syncs are decoded from the next-count values. They therefore change
  // on the same edge as x/y, with no one-pixel lag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      hsync_p1 <= 1'b1;
      vsync_p1 <= 1'b1;
    end else begin
      h_cnt    <= h_nxt_p0;
      v_cnt    <= v_nxt_p0;
      hsync_p1 <= ~in_window(h_nxt_p0, HS_FIRST, HS_FINAL);
      vsync_p1 <= ~in_window(v_nxt_p0, VS_FIRST, VS_FINAL);
    end
  end

`ifdef VGA_FRAME_TICK_EN
  logic frame_tick_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_tick_p1 <= 1'b0;
    end else begin
      frame_tick_p1 <= p_tick && h_last_p0 && v_last_p0;
    end
  end

  assign frame_tick = frame_tick_p1;
`endif

  assign x        = h_cnt;
  assign y        = v_cnt;
  assign hsync    = hsync_p1;
  assign vsync    = vsync_p1;
  assign video_on = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing generator directly upstream of the pong pixel generator.
- Derives the 25 MHz pixel-rate enable from the 100 MHz system clock.
- Runs the horizontal and vertical scan counters for 640x480 at 60 Hz.
- Drives hsync/vsync to the VGA connector, and x, y, video_on, p_tick to the pixel generator and the RGB output register.

Parameters:
- CLK_DIV, 4, system clocks per pixel (1..16); p_tick period.
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BACK, 48, horizontal back porch (pixels).
- V_DISPLAY, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BACK, 33, vertical back porch (lines).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset: 0 = reset asserted.
- hsync  output  1  horizontal sync, active low, registered.
- vsync  output  1  vertical sync, active low, registered.
- video_on  output  1  high while x < H_DISPLAY and y < V_DISPLAY.
- p_tick  output  1  one-clk pixel enable, once per CLK_DIV clocks.
- x  output  10  current horizontal count, 0..H_TOTAL-1.
- y  output  10  current vertical count, 0..V_TOTAL-1.

Behaviour:
- Derived totals: H_TOTAL = sum of the four H params (800); V_TOTAL = sum of the four V params (525).
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps.
  - p_tick = (div_cnt == CLK_DIV-1), combinational from the register.
  - CLK_DIV=1: p_tick is constantly 1.
- Counters update only on clk edges where p_tick=1:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0.
  - v_cnt increments only when h_cnt wraps; at V_TOTAL-1 together with the h wrap, v_cnt wraps to 0.
  - x = h_cnt, y = v_cnt, both direct from registers.
- Sync outputs:
  - hsync=0 exactly while x is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751.
  - vsync=0 exactly while y is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491.
  - Both are registered from the next-count values, so they change on the same edge as x/y with no skew.
- video_on is combinational from the counter registers; no pipeline delay relative to x/y.
- Downstream contract: y passes through 481 during x=0. The pixel generator keys its once-per-frame refresh on (y==481, x==0). That condition holds for CLK_DIV clocks, so refresh logic must qualify with p_tick when CLK_DIV>1.
- Reset asserted (reset=0, asynchronous):
  - div_cnt=0, x=0, y=0, hsync=1, vsync=1, p_tick=0 (CLK_DIV>1).
  - video_on=1, since (0,0) is visible.
- Reset released: first p_tick on the CLK_DIV-th rising edge.
- Reset mid-frame: all state returns immediately to the reset values. No partial sync pulse is held; hsync/vsync go high asynchronously.
- Width rule: counters are 10 bits. H_TOTAL and V_TOTAL must be ≤1024; larger values are unsupported.
- No other inputs; the block free-runs.

Optional Feature:
- Macro: VGA_FRAME_TICK_EN.
- Defined:
  - Adds output port frame_tick (1 bit, registered).
  - Pulses high for exactly one clk on the edge where counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - Reset value 0.
- Undefined: port absent; all other behaviour identical.

Test Plan:
- Reset → values: hold reset=0 for 5 clks → x=0, y=0, hsync=1, vsync=1, video_on=1, p_tick=0. Release → p_tick first high on the 4th rising edge, then every 4 clks.
- Line timing: run one line → x steps 0..799 then returns to 0 after 3200 clks, y increments by 1. hsync falls when x becomes 656, rises when x becomes 752 (96 ticks = 384 clks low).
- Blanking boundary: observe x=639→640 at y=10 → video_on 1→0 on the same edge. At y=479→480, video_on stays 0 for the whole line.
- Frame timing: run 525 lines → vsync low exactly while y=490..491 (1600 ticks = 6400 clks). Frame period 1,680,000 clks. (y==481, x==0) occurs once per frame.
- Mid-frame reset: assert reset=0 at x=700, y=491 (both syncs low) → hsync=1, vsync=1, x=0, y=0 without waiting for a clk edge. After release, timing restarts as in the first scenario.
- Frame tick (VGA_FRAME_TICK_EN defined): frame_tick is high for one clk coincident with (0,0) after (799,524), never elsewhere, and 0 during reset. With the macro undefined, the build elaborates without the port.
